suspi_frame_rx: RTL

Parametrised SUSPI serial frame receiver: the successor to the fixed 11-bit (start, 8 data LSB-first, odd parity, stop) COM-line receiver.
- Data width, parity mode, stop-bit count and bit period are configurable.
- Adds start-bit glitch rejection, per-word parity/framing flags and a FIFO output buffer with valid/ready handshake.
- Sits between the COM1/COM2 pins and the command/packet parser; one instance per line.

---
 rtl/suspi_frame_rx.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/suspi_frame_rx.sv
// SUSPI serial frame receiver: synchronised line input, start-glitch
// rejection, configurable data/parity/stop framing, per-word error flags
// and a first-word-fall-through output FIFO with valid/ready handshake.
module suspi_frame_rx #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 12,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 bb_clk_in,
  input  logic                 rst_l,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 ovf_err,
  input  logic                 clr_err,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned WW = DATA_BITS + 2;

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxs_d;
  logic                   w_rxs;

  logic [2:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_bit_idx;
  logic                   r_stop_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_push;
  logic [WW-1:0]          r_push_word;

  logic                   w_strobe;
  logic                   w_exp_par;
  logic                   w_last_stop;

  logic [WW-1:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic [WW-1:0]          r_last;
  logic                   r_ovf;
  logic [15:0]            r_frame_cnt;

  logic                   w_pop;
  logic                   w_full;
  logic                   w_accept;
  logic [WW-1:0]          w_head;

  assign w_rxs = r_sync[SYNC_STAGES-1];

  // Synchronise the asynchronous line and keep its previous value for edge detection
  always_ff @(posedge bb_clk_in or negedge rst_l) begin
    if (!rst_l) begin
      r_sync  <= '1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], rx_in};
      r_rxs_d <= w_rxs;
    end
  end

  // Half-bit strobe in START centres all later strobes on the bit cells
  always_comb begin
    w_strobe = 1'b0;
    if (r_state == S_START)
      w_strobe = (r_cnt == HALF_M1);
    else if ((r_state == S_DATA) || (r_state == S_PARITY) || (r_state == S_STOP))
      w_strobe = (r_cnt == FULL_M1);
  end

  assign w_exp_par   = (PARITY_MODE == 1) ? ~^r_shift : ^r_shift;
  assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;

  // Frame FSM: bit timing, shifting, error flags and the one-cycle push request
  always_ff @(posedge bb_clk_in or negedge rst_l) begin
    if (!rst_l) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_stop_idx  <= 1'b0;
      r_shift     <= '0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_push      <= 1'b0;
      r_push_word <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_strobe) r_cnt <= '0;
      else          r_cnt <= r_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (r_rxs_d && !w_rxs) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
          end
        end
        S_START: begin
          if (w_strobe) begin
            if (w_rxs) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
            end
          end
        end
        S_DATA: begin
          if (w_strobe) begin
            r_shift   <= {w_rxs, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == LAST_BIT) begin
              r_state    <= (PARITY_MODE == 0) ? S_STOP : S_PARITY;
              r_stop_idx <= 1'b0;
            end
          end
        end
        S_PARITY: begin
          if (w_strobe) begin
            r_perr     <= (w_rxs != w_exp_par);
            r_state    <= S_STOP;
            r_stop_idx <= 1'b0;
          end
        end
        S_STOP: begin
          if (w_strobe) begin
            if (w_last_stop) begin
              r_push      <= 1'b1;
              r_push_word <= {r_perr, r_ferr | ~w_rxs, r_shift};
              r_state     <= w_rxs ? S_IDLE : S_WAIT;
            end else begin
              r_ferr     <= r_ferr | ~w_rxs;
              r_stop_idx <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (w_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign w_pop    = (r_count != '0) && rx_ready;
  assign w_full   = (r_count == FULL_CNT);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_accept = r_push && (!w_full || w_pop);

  // FIFO storage; no reset needed since empty reads are served from r_last
  always_ff @(posedge bb_clk_in) begin
    if (w_accept) r_mem[r_wr_ptr] <= r_push_word;
  end

  // FIFO pointers, occupancy and the held copy of the last popped word
  always_ff @(posedge bb_clk_in or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= w_head;
      end
      if (w_accept && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_accept && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Sticky overflow flag (set beats clear) and error-free frame counter
  always_ff @(posedge bb_clk_in or negedge rst_l) begin
    if (!rst_l) begin
      r_ovf       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (r_push && !w_accept) r_ovf <= 1'b1;
      else if (clr_err)        r_ovf <= 1'b0;
      if (w_accept && !r_push_word[WW-1] && !r_push_word[WW-2])
        r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign rx_valid                     = (r_count != '0);
  assign {rx_perr, rx_ferr, rx_data}  = rx_valid ? w_head : r_last;
  assign ovf_err                      = r_ovf;
  assign frame_cnt                    = r_frame_cnt;
  assign busy                         = (r_state != S_IDLE);

endmodule
